adc_spi_frame_engine: RTL and testbench

Downstream serial stage for the ADC configuration path. It accepts one 24-bit register command at a time from the AXI-lite register block over a valid/ready handshake, and drives the ADC 3-wire serial port (SEN/SCLK/SDIN). For reads it captures SDOUT and returns 16-bit readback data with a single-cycle response strobe.

---
 rtl/adc_spi_pkg.sv | 19 +
 rtl/adc_spi_clkdiv.sv | 35 +++
 rtl/adc_spi_frame_engine.sv | 160 ++++++++++++++++
 tb/tb_adc_spi_frame_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC 3-wire serial frame engine.
// Holds the frame geometry, the position of the read/write bit and the
// frame sequencer state type.
package adc_spi_pkg;

  localparam int FRAME_W = 24;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int RW_BIT  = FRAME_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

endpackage

// File: rtl/adc_spi_clkdiv.sv
// Phase tick generator for the serial frame engine.
// A down-counter reloaded with CLK_DIV-1; tick pulses for one cycle when the
// count reaches zero. While clear is high the counter is held at its reload
// value so the first phase after clear is released lasts exactly CLK_DIV cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold counter at reload, suppress tick
//   tick       : one-cycle pulse at the end of every CLK_DIV-cycle phase
module adc_spi_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == '0) cnt_d = RELOAD;
    else                      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end

  assign tick = !clear && (cnt_q == '0);

endmodule

// File: rtl/adc_spi_frame_engine.sv
// ADC 3-wire serial frame engine.
// Accepts one 24-bit command {rw, addr[6:0], data[15:0]} over valid/ready,
// shifts it out MSB first on SEN/SCLK/SDIN and, for reads, returns the last
// 16 bits sampled from SDOUT with a one-cycle rsp_valid strobe.
//   S_AXI_ACLK, S_AXI_RESETN : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (ready only in IDLE)
//   cmd_rw/cmd_addr/cmd_data : command fields, registered at handshake
//   rsp_valid/rsp_data       : end-of-frame strobe and readback (0 for writes)
//   busy                     : frame in progress
//   spi_sen/sclk/sdin/sdout  : ADC serial port; outputs are registered
module adc_spi_frame_engine
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int CSB_SETUP = 2
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_RESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              spi_sen,
  output logic              spi_sclk,
  output logic              spi_sdin,
  input  logic              spi_sdout
);

  localparam int            SW         = (CSB_SETUP > 1) ? $clog2(CSB_SETUP) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'(CSB_SETUP - 1);
  localparam int            BW         = $clog2(FRAME_W);
  localparam logic [BW-1:0] BIT_MSB    = BW'(FRAME_W - 1);

  state_e               state_q, state_d;
  logic [SW-1:0]        setup_cnt_q, setup_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 hi_q, hi_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic                 rw_q, rw_d;
  logic                 fin_q, fin_d;
  logic                 sen_q, sen_d;
  logic                 sclk_q, sclk_d;
  logic                 sdin_q, sdin_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic [FRAME_W-1:0]   frame_in;
  logic                 div_clear;
  logic                 phase_tick;

  assign frame_in  = {cmd_rw, cmd_addr, cmd_data};
  // Divider only runs once shifting starts so SHIFT phases are CLK_DIV-aligned.
  assign div_clear = (state_q == IDLE) || (state_q == SETUP);

  adc_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_RESETN),
    .clear (div_clear),
    .tick  (phase_tick)
  );

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    hi_d        = hi_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    fin_d       = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        state_d     = SETUP;
        tx_d        = frame_in;
        rw_d        = frame_in[RW_BIT];
        setup_cnt_d = SETUP_LAST;
        bit_cnt_d   = BIT_MSB;
        hi_d        = 1'b0;
      end
      SETUP: begin
        if (setup_cnt_q == '0) state_d = SHIFT;
        else                   setup_cnt_d = setup_cnt_q - 1'b1;
      end
      SHIFT: if (phase_tick) begin
        if (!hi_q) begin
          hi_d = 1'b1;
        end else if (bit_cnt_q == '0) begin
          hi_d    = 1'b0;
          state_d = HOLD;
        end else begin
          hi_d      = 1'b0;
          bit_cnt_d = bit_cnt_q - 1'b1;
          tx_d      = {tx_q[FRAME_W-2:0], 1'b0};
        end
      end
      HOLD: if (phase_tick) begin
        state_d = GAP;
        fin_d   = 1'b1;
      end
      GAP: if (phase_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the current state and registered, so every
  // serial output (and the response) lags the state register by one cycle.
  always_comb begin
    sen_d       = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
    sclk_d      = (state_q == SHIFT) && hi_q;
    sdin_d      = sen_d ? 1'b0 : tx_q[FRAME_W-1];
    rx_d        = (sclk_d && !sclk_q) ? {rx_q[DATA_W-2:0], spi_sdout} : rx_q;
    rsp_valid_d = fin_q;
    rsp_data_d  = rsp_data_q;
    if (fin_q) rsp_data_d = rw_q ? rx_q : '0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_RESETN) begin
    if (!S_AXI_RESETN) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      bit_cnt_q   <= '0;
      hi_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      fin_q       <= 1'b0;
      sen_q       <= 1'b1;
      sclk_q      <= 1'b0;
      sdin_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hi_q        <= hi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      fin_q       <= fin_d;
      sen_q       <= sen_d;
      sclk_q      <= sclk_d;
      sdin_q      <= sdin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign spi_sen   = sen_q;
  assign spi_sclk  = sclk_q;
  assign spi_sdin  = sdin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_adc_spi_frame_engine.sv
// Bench for adc_spi_frame_engine: two instances (defaults, and CLK_DIV=1 /
// CSB_SETUP=1) run side by side. A frame-offset model predicts every output
// from the cycle count since the handshake; an ADC model answers reads.
module tb_adc_spi_frame_engine;

  localparam int NI  = 2;
  localparam int BIG = 1000000;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction
  function automatic int set_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int t_of(input int i);
    return 1 + set_of(i) + 49 * div_of(i);
  endfunction

  logic        clk;
  logic        rst_n     [NI];
  logic        cmd_valid [NI];
  logic        cmd_ready [NI];
  logic        cmd_rw    [NI];
  logic [6:0]  cmd_addr  [NI];
  logic [15:0] cmd_data  [NI];
  logic        rsp_valid [NI];
  logic [15:0] rsp_data  [NI];
  logic        busy      [NI];
  logic        sen       [NI];
  logic        sclk      [NI];
  logic        sdin      [NI];
  logic        sdout     [NI];

  adc_spi_frame_engine #(.CLK_DIV(4), .CSB_SETUP(2)) u_dut0 (
    .S_AXI_ACLK(clk), .S_AXI_RESETN(rst_n[0]), .cmd_valid(cmd_valid[0]),
    .cmd_ready(cmd_ready[0]), .cmd_rw(cmd_rw[0]), .cmd_addr(cmd_addr[0]),
    .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .spi_sen(sen[0]), .spi_sclk(sclk[0]), .spi_sdin(sdin[0]),
    .spi_sdout(sdout[0]));

  adc_spi_frame_engine #(.CLK_DIV(1), .CSB_SETUP(1)) u_dut1 (
    .S_AXI_ACLK(clk), .S_AXI_RESETN(rst_n[1]), .cmd_valid(cmd_valid[1]),
    .cmd_ready(cmd_ready[1]), .cmd_rw(cmd_rw[1]), .cmd_addr(cmd_addr[1]),
    .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .spi_sen(sen[1]), .spi_sclk(sclk[1]), .spi_sdin(sdin[1]),
    .spi_sdout(sdout[1]));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model state
  int          m_k      [NI];
  logic [23:0] m_frame  [NI];
  logic [15:0] m_word   [NI];
  logic [15:0] m_rsp    [NI];
  int          hs_count [NI];
  int          hs_cycle [NI];
  int          prev_hs  [NI];
  logic [15:0] adc_word [NI];

  // monitor state
  logic [23:0] cap      [NI];
  int          cap_n    [NI];
  int          rises    [NI];
  logic        prev_sclk[NI];
  int          rsp_cnt  [NI];
  int          rsp_cyc  [NI];
  logic [15:0] rsp_last [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Frame-offset model: k = edges since the accepting edge.
  always @(posedge clk) begin : model
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        m_k[i]   = BIG;
        m_rsp[i] = '0;
      end else if (m_k[i] < t_of(i) - 1 + div_of(i)) begin
        m_k[i]++;
        if (m_k[i] == t_of(i)) m_rsp[i] = m_frame[i][23] ? m_word[i] : 16'h0000;
      end else if (cmd_valid[i]) begin
        m_k[i]      = 0;
        m_frame[i]  = {cmd_rw[i], cmd_addr[i], cmd_data[i]};
        m_word[i]   = adc_word[i];
        hs_count[i]++;
        prev_hs[i]  = hs_cycle[i];
        hs_cycle[i] = cyc;
      end else if (m_k[i] < BIG) begin
        m_k[i]++;
      end
    end
  end

  always @(negedge clk) begin : compare
    int k, j, dd, ss, tt, b;
    logic        e_sclk;
    logic [15:0] e_rsp;
    for (int i = 0; i < NI; i++) begin
      dd = div_of(i); ss = set_of(i); tt = t_of(i);
      k  = rst_n[i] ? m_k[i] : BIG;
      e_rsp = rst_n[i] ? m_rsp[i] : 16'h0000;
      j  = k - 1 - ss;
      e_sclk = (j >= 0 && j < 48 * dd) && (((j / dd) % 2) == 1);
      check("cmd_ready", i, cmd_ready[i], k >= tt - 1 + dd);
      check("busy", i, busy[i], k < tt - 1 + dd);
      check("sen", i, sen[i], !(k >= 1 && k < tt));
      check("sclk", i, sclk[i], e_sclk);
      check("rsp_valid", i, rsp_valid[i], k == tt);
      check("rsp_data", i, rsp_data[i], e_rsp);
      if (k >= 1 && k <= ss) check("sdin_setup", i, sdin[i], m_frame[i][23]);
      if (j >= 0 && j < 48 * dd) begin
        b = 23 - j / (2 * dd);
        check("sdin_shift", i, sdin[i], m_frame[i][b]);
      end
      // monitor
      if (k == 0) begin cap[i] = '0; cap_n[i] = 0; end
      if (sclk[i] && !prev_sclk[i]) begin
        cap[i] = {cap[i][22:0], sdin[i]};
        cap_n[i]++;
      end
      if (rsp_valid[i]) begin
        rsp_cnt[i]++;
        rsp_cyc[i]  = cyc - hs_cycle[i];
        rsp_last[i] = rsp_data[i];
      end
      // ADC: present the bit for the next sclk rise
      if (sen[i]) rises[i] = 0;
      else if (sclk[i] && !prev_sclk[i]) rises[i]++;
      prev_sclk[i] = sclk[i];
      if (rises[i] >= 8 && rises[i] <= 23) sdout[i] = m_word[i][23 - rises[i]];
      else sdout[i] = 1'($urandom);
    end
  end

  // Called at posedge+2.
  task automatic send(input int i, input logic rw, input logic [6:0] a,
                      input logic [15:0] d, input logic [15:0] w, input bit keep);
    int h0;
    int n;
    h0 = hs_count[i];
    n  = 0;
    cmd_rw[i] = rw; cmd_addr[i] = a; cmd_data[i] = d; adc_word[i] = w;
    cmd_valid[i] = 1'b1;
    while (hs_count[i] == h0 && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    if (hs_count[i] == h0) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout[%0d] got=none exp=handshake", i);
    end
    if (!keep) cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (m_k[i] < t_of(i) - 1 + div_of(i) && n < 2000) begin
      if (!cmd_valid[i]) begin
        cmd_rw[i]   = 1'($urandom);
        cmd_addr[i] = 7'($urandom);
        cmd_data[i] = 16'($urandom);
      end
      @(posedge clk); #2; n++;
    end
    if (n >= 2000) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout[%0d] got=busy exp=idle", i);
    end
    @(posedge clk); #2;
  endtask

  task automatic run(input int i);
    int r0, n;
    // directed write
    send(i, 1'b0, 7'h25, 16'hA5C3, 16'h1234, 1'b0);
    wait_done(i);
    check("wr_sdin_word", i, cap[i], 24'h25A5C3);
    check("wr_rises", i, cap_n[i], 24);
    check("wr_rsp_time", i, rsp_cyc[i], (i == 0) ? 199 : 51);
    check("wr_rsp_data", i, rsp_last[i], 16'h0000);
    // directed read
    send(i, 1'b1, 7'h01, 16'h0000, 16'hBEEF, 1'b0);
    wait_done(i);
    check("rd_hdr", i, cap[i][23:16], 8'h81);
    check("rd_rsp_data", i, rsp_last[i], 16'hBEEF);
    // back-to-back with cmd_valid held
    send(i, 1'b1, 7'h11, 16'h0F0F, 16'hC001, 1'b1);
    send(i, 1'b0, 7'h22, 16'h5555, 16'h0000, 1'b0);
    check("b2b_spacing", i, hs_cycle[i] - prev_hs[i], (i == 0) ? 203 : 52);
    wait_done(i);
    // reset at bit 10 of SHIFT
    if (i == 0) begin
      r0 = rsp_cnt[0];
      send(0, 1'b1, 7'h33, 16'h0000, 16'h7E57, 1'b0);
      n = 0;
      while (m_k[0] != 107 && n < 500) begin @(posedge clk); #2; n++; end
      check("rst_reach_bit10", 0, m_k[0], 107);
      rst_n[0] = 1'b0;
      #1;
      check("rst_sen", 0, sen[0], 1'b1);
      check("rst_sclk", 0, sclk[0], 1'b0);
      check("rst_ready", 0, cmd_ready[0], 1'b1);
      check("rst_rsp_valid", 0, rsp_valid[0], 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n[0] = 1'b1;
      @(posedge clk); #2;
      send(0, 1'b1, 7'h44, 16'h0000, 16'hA11C, 1'b0);
      wait_done(0);
      check("rst_no_stray_rsp", 0, rsp_cnt[0], r0 + 1);
      check("rst_next_rsp", 0, rsp_last[0], 16'hA11C);
    end
    // random traffic
    for (int c = 0; c < ((i == 0) ? 8 : 30); c++) begin
      send(i, 1'($urandom), 7'($urandom), 16'($urandom), 16'($urandom),
           bit'($urandom_range(0, 1)));
      if (!cmd_valid[i]) begin
        wait_done(i);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      end
    end
    cmd_valid[i] = 1'b0;
    wait_done(i);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_rw[i] = 1'b0;
      cmd_addr[i] = '0; cmd_data[i] = '0; adc_word[i] = '0;
      m_k[i] = BIG; m_frame[i] = '0; m_word[i] = '0; m_rsp[i] = '0;
      hs_count[i] = 0; hs_cycle[i] = 0; prev_hs[i] = 0;
      cap[i] = '0; cap_n[i] = 0; rises[i] = 0; prev_sclk[i] = 1'b0;
      rsp_cnt[i] = 0; rsp_cyc[i] = 0; rsp_last[i] = '0; sdout[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #2;
    fork
      run(0);
      run(1);
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
